pma_region_checker: RTL and testbench
=====================================

Name: pma_region_checker

Overview:
- Runtime-programmable physical memory attribute (PMA) checker.
- Holds NrRegions base/length regions. Each region carries attribute bits: nonidempotent, execute, cacheable, shared, lock.
- Serves NrPorts independent lookup channels through a 2-stage valid/ready pipeline.
- Sits between the address-generating units (frontend, LSU, PTW) and the memory interfaces. Replaces the fixed, elaboration-time region rules with CSR-programmable ones.

Parameters:
- NrRegions, 16, number of programmable regions (1..64)
- NrPorts, 2, number of independent lookup channels (1..4)
- AddrWidth, 64, physical address width (32..64)
- RegionIdxW, $clog2(NrRegions), derived; region index width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_we_i  in  1  region write strobe
- cfg_idx_i  in  RegionIdxW  region to write
- cfg_base_i  in  AddrWidth  region base address
- cfg_len_i  in  AddrWidth  region length in bytes; 0 disables the region
- cfg_attr_i  in  5  {lock, shared, cacheable, execute, nonidem}
- cfg_err_o  out  1  one-cycle pulse: write to a locked region or an out-of-range index
- req_valid_i  in  NrPorts  lookup request valid
- req_ready_o  out  NrPorts  lookup request ready
- req_addr_i  in  NrPorts*AddrWidth  lookup address
- resp_valid_o  out  NrPorts  response valid
- resp_ready_i  in  NrPorts  response ready
- resp_hit_o  out  NrPorts  address matched at least one region
- resp_idx_o  out  NrPorts*RegionIdxW  lowest matching region index; 0 on miss
- resp_attr_o  out  NrPorts*4  OR of {shared, cacheable, execute, nonidem} over all matching regions

Behaviour:
- Reset: every region has base=0, len=0, attr=0, i.e. disabled and unlocked. cfg_err_o=0, resp_valid_o=0, pipeline empty. req_ready_o=1 from the first cycle after reset deasserts.
- Match rule for region k: addr >= base && {1'b0,addr} < base+len. The sum is computed at AddrWidth+1 bits, so the end address never wraps. len=0 never matches.
- Config write: a write with cfg_we_i=1 updates the region at the clock edge. The new values are visible to requests accepted from the next cycle onward.
- A request accepted in the same cycle as a write sees the old region values.
- A write to a region with lock=1, or with cfg_idx_i >= NrRegions, is ignored. cfg_err_o pulses high the following cycle.
- Lock is set by writing attr[4]=1 and is cleared only by rst_i.
- Per-port pipeline: each port is independent, and ports never stall one another.
  - S1 registers the NrRegions-bit hit vector. The comparison is made against the region registers at acceptance time.
  - S2 registers hit, lowest-index priority encode, and OR-reduced attributes.
- Latency: the response appears 2 cycles after acceptance.
- Throughput: 1 request per cycle per port when resp_ready_i=1.
- Handshake: elastic pipeline.
  - S2 advances when !s2_valid || resp_ready_i.
  - S1 advances when S2 can accept.
  - req_ready_o = !s1_valid || s1_advance.
  - resp_* are held stable while resp_valid_o=1 && !resp_ready_i.
  - No bubbles under continuous flow; no request is lost or duplicated under arbitrary backpressure.
- Miss: resp_hit_o=0, resp_idx_o=0, resp_attr_o=0.
- Overlapping regions: attributes are ORed; resp_idx_o reports the lowest matching index.
- rst_i mid-operation flushes both stages. Responses in flight are dropped and resp_valid_o=0 in the next cycle.

Optional Feature:
- Macro: PMA_REGION_CHECKER_MISS_CNT_EN.
- When defined:
  - Extra output miss_cnt_o, NrPorts*32 bits.
  - Each port counts completed response handshakes with resp_hit_o=0.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: no port, no counters, no added logic.

Decomposition:
- Package pma_pkg holds:
  - typedef pma_attr_t: packed {lock, shared, cacheable, execute, nonidem}
  - typedef pma_region_t: packed {base, len, attr}, parameterised by AddrWidth via a localparam max of 64 with truncation
  - localparam PMA_ATTR_W=5
- Sub-module pma_range_cmp: a single combinational base/len/address comparator with 65-bit extension. Instantiated NrRegions*NrPorts times.

Test Plan:
1. Reset, then lookup 0x8000_0000 on port0 -> 2 cycles later resp_valid=1, hit=0, idx=0, attr=0.
2. Write region 3 with base=0x8000_0000, len=0x1000, attr=cacheable|execute. Lookups at 0x8000_0FFF and 0x8000_1000 -> first: hit=1, idx=3, attr=0b0110; second: hit=0.
3. Region 0 = [0x0, 0x1_0000) nonidem; region 5 = [0x8000, 0x1_8000) shared. Lookup 0x9000 -> hit=1, idx=0, attr=0b1001.
4. Write region 2 with lock=1, then rewrite region 2 with len=0 -> cfg_err_o pulses 1 cycle later, and lookups still match the original region 2.
5. Region base=0xFFFF_FFFF_FFFF_F000, len=0x1000. Lookup 0xFFFF_FFFF_FFFF_FFFF -> hit=1. Lookup 0x0 -> hit=0 (no wrap).
6. Port1: 8 back-to-back requests with resp_ready toggled randomly; port0 held with resp_ready=0 -> port1 returns all 8 responses in order, unaffected. Port0 holds a stable response. Asserting rst_i mid-stream gives resp_valid=0 on the next cycle.

Source files
------------

// File: rtl/pma_pkg.sv
// Shared types for the PMA region checker: attribute and region records.
// Region fields are held at the 64-bit maximum address width. Narrower
// configurations zero-extend into them, and synthesis trims the constant bits.
package pma_pkg;

    localparam int PMA_ATTR_W = 5;
    localparam int PMA_MAX_AW = 64;
    localparam int PMA_RESP_ATTR_W = 4;

    typedef struct packed {
        logic lock;
        logic shared;
        logic cacheable;
        logic execute;
        logic nonidem;
    } pma_attr_t;

    typedef struct packed {
        logic [PMA_MAX_AW-1:0] base;
        logic [PMA_MAX_AW-1:0] len;
        pma_attr_t             attr;
    } pma_region_t;

    // Attribute bits that leave the checker. The lock bit is configuration-only.
    function automatic logic [PMA_RESP_ATTR_W-1:0] pma_resp_attr(input pma_attr_t a);
        return {a.shared, a.cacheable, a.execute, a.nonidem};
    endfunction

endpackage

// File: rtl/pma_range_cmp.sv
// Single base/length range comparator. The end address is formed one bit
// wider than the address, so a region that touches the top of the address
// space never wraps around to zero.
module pma_range_cmp
    import pma_pkg::*;
(
    input  logic [PMA_MAX_AW-1:0] addr,
    input  logic [PMA_MAX_AW-1:0] base,
    input  logic [PMA_MAX_AW-1:0] len,
    output logic                  hit
);

    logic [PMA_MAX_AW:0] end_addr;

    assign end_addr = {1'b0, base} + {1'b0, len};

    // A zero length is an explicit disable, independent of the base value.
    assign hit = (len != '0) && (addr >= base) && ({1'b0, addr} < end_addr);

endmodule

// File: rtl/pma_region_checker.sv
// Runtime-programmable physical memory attribute checker.
// NrRegions base/length regions are written through a simple config port.
// NrPorts independent lookup channels each run a 2-stage elastic pipeline:
// S1 holds the hit vector, and S2 holds the hit flag, lowest index and ORed attributes.
// Optional feature: define PMA_REGION_CHECKER_MISS_CNT_EN to add per-port
// saturating counters of completed miss responses (miss_cnt_o).
module pma_region_checker
    import pma_pkg::*;
#(
    parameter int NrRegions  = 16,
    parameter int NrPorts    = 2,
    parameter int AddrWidth  = 64,
    parameter int RegionIdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
`ifdef PMA_REGION_CHECKER_MISS_CNT_EN
    output logic [NrPorts*32-1:0]           miss_cnt_o,
`endif
    input  logic                            cfg_we_i,
    input  logic [RegionIdxW-1:0]           cfg_idx_i,
    input  logic [AddrWidth-1:0]            cfg_base_i,
    input  logic [AddrWidth-1:0]            cfg_len_i,
    input  logic [PMA_ATTR_W-1:0]           cfg_attr_i,
    output logic                            cfg_err_o,
    input  logic [NrPorts-1:0]              req_valid_i,
    output logic [NrPorts-1:0]              req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]    req_addr_i,
    output logic [NrPorts-1:0]              resp_valid_o,
    input  logic [NrPorts-1:0]              resp_ready_i,
    output logic [NrPorts-1:0]              resp_hit_o,
    output logic [NrPorts*RegionIdxW-1:0]   resp_idx_o,
    output logic [NrPorts*PMA_RESP_ATTR_W-1:0] resp_attr_o
);

    pma_region_t            regions [NrRegions];
    pma_region_t            wdata;
    logic [NrRegions-1:0]   locked;
    logic [NrRegions-1:0]   wr_en;
    logic                   sel_locked;
    logic                   idx_oob;

    logic [NrPorts-1:0][NrRegions-1:0] hitvec;

    // ------------------------------------------------------------------
    // Region configuration
    // ------------------------------------------------------------------
    assign wdata.base = PMA_MAX_AW'(cfg_base_i);
    assign wdata.len  = PMA_MAX_AW'(cfg_len_i);
    assign wdata.attr = pma_attr_t'(cfg_attr_i);

    assign idx_oob = int'(cfg_idx_i) >= NrRegions;

    for (genvar k = 0; k < NrRegions; k++) begin : g_lock
        assign locked[k] = regions[k].attr.lock;
        assign wr_en[k]  = cfg_we_i && (int'(cfg_idx_i) == k) && !locked[k];
    end

    // Lock state of the addressed region. This avoids indexing past the array on an out-of-range index.
    always_comb begin
        sel_locked = 1'b0;
        for (int k = 0; k < NrRegions; k++) begin
            if (int'(cfg_idx_i) == k) sel_locked = locked[k];
        end
    end

    // Region registers: cleared on reset, and rewritten only while unlocked.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrRegions; k++) begin
            if (rst_i) begin
                regions[k] <= '0;
            end else if (wr_en[k]) begin
                regions[k] <= wdata;
            end
        end
    end

    // Rejected writes (locked target or bad index) pulse the error for one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && (idx_oob || sel_locked);
        end
    end

    // ------------------------------------------------------------------
    // Per-port lookup pipelines
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        logic [PMA_MAX_AW-1:0]      addr_ext;
        logic                       s1_valid;
        logic                       s1_adv;
        logic [NrRegions-1:0]       s1_hits;
        logic [PMA_RESP_ATTR_W-1:0] s1_attr;
        logic [PMA_RESP_ATTR_W-1:0] acc_attr;
        logic [RegionIdxW-1:0]      enc_idx;
        logic                       s2_valid;
        logic                       s2_adv;
        logic                       s2_hit;
        logic [RegionIdxW-1:0]      s2_idx;
        logic [PMA_RESP_ATTR_W-1:0] s2_attr;

        assign addr_ext = PMA_MAX_AW'(req_addr_i[p*AddrWidth +: AddrWidth]);

        for (genvar k = 0; k < NrRegions; k++) begin : g_cmp
            pma_range_cmp u_cmp (
                .addr (addr_ext),
                .base (regions[k].base),
                .len  (regions[k].len),
                .hit  (hitvec[p][k])
            );
        end

        // Attributes are ORed against the same region snapshot as the hit vector,
        // so a later write cannot leak into an in-flight lookup.
        always_comb begin
            acc_attr = '0;
            for (int k = 0; k < NrRegions; k++) begin
                if (hitvec[p][k]) acc_attr = acc_attr | pma_resp_attr(regions[k].attr);
            end
        end

        // Lowest matching index wins. Scanning downward lets the last assignment take priority.
        always_comb begin
            enc_idx = '0;
            for (int k = NrRegions - 1; k >= 0; k--) begin
                if (s1_hits[k]) enc_idx = RegionIdxW'(k);
            end
        end

        assign s2_adv         = !s2_valid || resp_ready_i[p];
        assign s1_adv         = s2_adv;
        assign req_ready_o[p] = !s1_valid || s1_adv;

        // S1: capture hit vector and attribute OR at acceptance.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_valid <= 1'b0;
                s1_hits  <= '0;
                s1_attr  <= '0;
            end else if (s1_adv) begin
                s1_valid <= req_valid_i[p];
                s1_hits  <= hitvec[p];
                s1_attr  <= acc_attr;
            end
        end

        // S2: the response register. It is held while the consumer stalls.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s2_valid <= 1'b0;
                s2_hit   <= 1'b0;
                s2_idx   <= '0;
                s2_attr  <= '0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
                s2_hit   <= |s1_hits;
                s2_idx   <= enc_idx;
                s2_attr  <= s1_attr;
            end
        end

        assign resp_valid_o[p]                                 = s2_valid;
        assign resp_hit_o[p]                                   = s2_hit;
        assign resp_idx_o[p*RegionIdxW +: RegionIdxW]          = s2_idx;
        assign resp_attr_o[p*PMA_RESP_ATTR_W +: PMA_RESP_ATTR_W] = s2_attr;

`ifdef PMA_REGION_CHECKER_MISS_CNT_EN
        logic [31:0] miss_cnt;

        // Count completed miss handshakes. The counter saturates rather than wraps.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                miss_cnt <= '0;
            end else if (s2_valid && resp_ready_i[p] && !s2_hit && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end

        assign miss_cnt_o[p*32 +: 32] = miss_cnt;
`endif
    end

endmodule

// File: tb/tb_pma_region_checker.sv
// Directed bench for pma_region_checker (default parameters: 16 regions,
// 2 ports, 64-bit addresses). Inputs change 1 time unit after the rising edge,
// and outputs are sampled there as well.
module tb_pma_region_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [3:0]   cfg_idx;
    logic [63:0]  cfg_base;
    logic [63:0]  cfg_len;
    logic [4:0]   cfg_attr;
    logic         cfg_err;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_addr;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [1:0]   resp_hit;
    logic [7:0]   resp_idx;
    logic [7:0]   resp_attr;
`ifdef PMA_REGION_CHECKER_MISS_CNT_EN
    logic [63:0]  miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pma_region_checker dut (
        .clk_i        (clk),
        .rst_i        (rst),
`ifdef PMA_REGION_CHECKER_MISS_CNT_EN
        .miss_cnt_o   (miss_cnt),
`endif
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_base_i   (cfg_base),
        .cfg_len_i    (cfg_len),
        .cfg_attr_i   (cfg_attr),
        .cfg_err_o    (cfg_err),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_hit_o   (resp_hit),
        .resp_idx_o   (resp_idx),
        .resp_attr_o  (resp_attr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [63:0] base,
                             input logic [63:0] len, input logic [4:0] attr);
        cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_len = len; cfg_attr = attr;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Port-0 lookup on an idle pipeline: the response must appear exactly 2 cycles after acceptance.
    task automatic lookup0(input string tag, input logic [63:0] a, input logic eh,
                           input logic [3:0] ei, input logic [3:0] ea);
        chk({tag, " ready"}, 64'(req_ready[0]), 64'd1);
        req_valid[0] = 1'b1; req_addr[63:0] = a;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk({tag, " early"}, 64'(resp_valid[0]), 64'd0);
        @(posedge clk); #1;
        chk({tag, " valid"}, 64'(resp_valid[0]), 64'd1);
        chk({tag, " hit"},   64'(resp_hit[0]),   64'(eh));
        chk({tag, " idx"},   64'(resp_idx[3:0]), 64'(ei));
        chk({tag, " attr"},  64'(resp_attr[3:0]), 64'(ea));
    endtask

    // Watchdog: the run below is bounded, and this only guards against a wedged simulator.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] p1_addr [8];
    logic        p1_hit  [8];
    logic [3:0]  p1_idx  [8];
    logic [3:0]  p1_attr [8];
    int sent, recv;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0; cfg_attr = '0;
        req_valid = '0; req_addr = '0; resp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst cfg_err",    64'(cfg_err),    64'd0);
        chk("rst req_ready",  64'(req_ready),  64'd3);

        // 1: miss on empty table
        lookup0("t1 miss", 64'h8000_0000, 1'b0, 4'd0, 4'b0000);

        // 2: region 3, cacheable|execute, end boundary
        cfg_write(4'd3, 64'h8000_0000, 64'h1000, 5'b00110);
        chk("t2 cfg_err", 64'(cfg_err), 64'd0);
        lookup0("t2 last", 64'h8000_0FFF, 1'b1, 4'd3, 4'b0110);
        lookup0("t2 end",  64'h8000_1000, 1'b0, 4'd0, 4'b0000);

        // 3: overlapping regions 0 and 5
        cfg_write(4'd0, 64'h0,    64'h1_0000, 5'b00001);
        cfg_write(4'd5, 64'h8000, 64'h1_0000, 5'b01000);
        lookup0("t3 overlap", 64'h9000,   1'b1, 4'd0, 4'b1001);
        lookup0("t3 only5",   64'h1_0000, 1'b1, 4'd5, 4'b1000);
        lookup0("t3 miss",    64'h2_0000, 1'b0, 4'd0, 4'b0000);

        // 4: lock region 2, then a rejected rewrite
        cfg_write(4'd2, 64'h4000_0000, 64'h100, 5'b10100);
        chk("t4 lock cfg_err", 64'(cfg_err), 64'd0);
        cfg_write(4'd2, 64'h4000_0000, 64'h0, 5'b00000);
        chk("t4 err pulse", 64'(cfg_err), 64'd1);
        @(posedge clk); #1;
        chk("t4 err clear", 64'(cfg_err), 64'd0);
        lookup0("t4 locked", 64'h4000_0080, 1'b1, 4'd2, 4'b0100);

        // A request accepted in the same cycle as a write sees the old table
        cfg_we = 1'b1; cfg_idx = 4'd7; cfg_base = 64'h5000_0000; cfg_len = 64'h10; cfg_attr = 5'b00001;
        req_valid[0] = 1'b1; req_addr[63:0] = 64'h5000_0000;
        @(posedge clk); #1;
        cfg_we = 1'b0; req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("same-cycle valid", 64'(resp_valid[0]), 64'd1);
        chk("same-cycle hit",   64'(resp_hit[0]),   64'd0);
        lookup0("after write", 64'h5000_0000, 1'b1, 4'd7, 4'b0001);

        // 5: reset clears regions and locks. Then check the top-of-space region without wrap.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_write(4'd2, 64'h0, 64'h0, 5'b00000);
        chk("t5 unlocked", 64'(cfg_err), 64'd0);
        lookup0("t5 cleared", 64'h4000_0080, 1'b0, 4'd0, 4'b0000);
        cfg_write(4'd8, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 5'b00000);
        lookup0("t5 top",   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd8, 4'b0000);
        lookup0("t5 zero",  64'h0,                   1'b0, 4'd0, 4'b0000);
        lookup0("t5 below", 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd0, 4'b0000);

        // 6: port 0 stalled with a held response, while port 1 streams under random backpressure
        cfg_write(4'd1, 64'h1000, 64'h200, 5'b00100);
        cfg_write(4'd4, 64'h1200, 64'h100, 5'b01000);
        for (int j = 0; j < 8; j++) begin
            p1_addr[j] = 64'h1000 + 64'(j) * 64'h80;
            p1_hit[j]  = (j < 6);
            p1_idx[j]  = (j < 4) ? 4'd1 : ((j < 6) ? 4'd4 : 4'd0);
            p1_attr[j] = (j < 4) ? 4'b0100 : ((j < 6) ? 4'b1000 : 4'b0000);
        end
        resp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_addr[63:0] = 64'hFFFF_FFFF_FFFF_F800;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("p0 held valid", 64'(resp_valid[0]), 64'd1);

        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            resp_ready[1] = 1'($urandom_range(0, 1));
            req_valid[1]  = (sent < 8);
            if (sent < 8) req_addr[127:64] = p1_addr[sent];
            #1;
            if (resp_valid[1] && resp_ready[1]) begin
                chk($sformatf("p1 hit %0d", recv),  64'(resp_hit[1]),   64'(p1_hit[recv]));
                chk($sformatf("p1 idx %0d", recv),  64'(resp_idx[7:4]), 64'(p1_idx[recv]));
                chk($sformatf("p1 attr %0d", recv), 64'(resp_attr[7:4]), 64'(p1_attr[recv]));
                recv++;
            end
            if (req_valid[1] && req_ready[1]) sent++;
            chk("p0 stable", {61'd0, resp_valid[0], resp_hit[0], 1'b0} | 64'(resp_idx[3:0]) << 8,
                (64'd1 << 2) | (64'd1 << 1) | (64'd8 << 8));
            @(posedge clk); #1;
        end
        chk("p1 count", 64'(recv), 64'd8);
        req_valid[1] = 1'b0;

        // Reset mid-stream flushes both ports
        resp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_addr[127:64] = 64'h1000;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre-rst valid", 64'(resp_valid), 64'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst flush", 64'(resp_valid), 64'd0);
        rst = 1'b0; req_valid = '0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
